// File: rtl/rep_window_if.sv
// Signal bundle for rep_window_checker: per-channel sequence terms in,
// per-channel verdicts out.
interface rep_window_if #(
  parameter int NCH = 4,
  parameter int CW  = 8
);
  logic              en;
  logic [NCH-1:0]    trig;
  logic [NCH-1:0]    cond;
  logic [NCH-1:0]    done;
  logic [NCH-1:0]    active;
  logic [NCH-1:0]    pass;
  logic [NCH-1:0]    fail;
  logic [2*NCH-1:0]  fail_code;
  logic [CW*NCH-1:0] run_len;
  logic              err_sticky;

  modport master (
    output en, trig, cond, done,
    input  active, pass, fail, fail_code, run_len, err_sticky
  );

  modport slave (
    input  en, trig, cond, done,
    output active, pass, fail, fail_code, run_len, err_sticky
  );
endinterface

// File: rtl/rep_window_checker.sv
// Per-channel checker for "trig ##1 cond[*MIN_REP:MAX_REP] ##1 done".
// Each channel runs an IDLE/RUN FSM with a saturating run counter.
module rep_window_checker #(
  parameter int NCH     = 4,
  parameter int MIN_REP = 2,
  parameter int MAX_REP = 4,
  parameter int CW      = 8
) (
  input logic        clk,
  input logic        rst,
  rep_window_if.slave bus
);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam logic [CW-1:0] MAX_C = CW'(MAX_REP);
  localparam logic [CW:0]   MIN_W = (CW+1)'(MIN_REP);
  localparam logic [CW-1:0] SAT   = {CW{1'b1}};

  state_t            state_q [NCH];
  state_t            state_d [NCH];
  logic [CW-1:0]     cnt_q   [NCH];
  logic [CW-1:0]     cnt_d   [NCH];
  logic [NCH-1:0]    pass_q, pass_d;
  logic [NCH-1:0]    fail_q, fail_d;
  logic [2*NCH-1:0]  code_q, code_d;
  logic [CW*NCH-1:0] len_q, len_d;
  logic              err_q, err_d;
  logic [NCH-1:0]    active_w;

  always_comb begin
    pass_d = '0;
    fail_d = '0;
    code_d = code_q;
    len_d  = len_q;
    for (int i = 0; i < NCH; i++) begin
      state_d[i] = state_q[i];
      cnt_d[i]   = cnt_q[i];
      if (!bus.en) begin
        state_d[i] = IDLE;
      end else begin
        case (state_q[i])
          IDLE: begin
            if (bus.trig[i]) begin
              state_d[i] = RUN;
              cnt_d[i]   = '0;
            end
          end
          RUN: begin
            if (bus.cond[i]) begin
              // In a bounded build cnt never passes MAX_C, so equality marks overrun
              if (MAX_REP != 0 && cnt_q[i] == MAX_C) begin
                fail_d[i]            = 1'b1;
                code_d[2*i +: 2]     = 2'b10;
                len_d[CW*i +: CW]    = cnt_q[i];
                state_d[i]           = IDLE;
              end else if (cnt_q[i] != SAT) begin
                cnt_d[i] = cnt_q[i] + 1'b1;
              end
            end else begin
              len_d[CW*i +: CW] = cnt_q[i];
              state_d[i]        = IDLE;
              if ({1'b0, cnt_q[i]} < MIN_W) begin
                fail_d[i]        = 1'b1;
                code_d[2*i +: 2] = 2'b01;
              end else if (!bus.done[i]) begin
                fail_d[i]        = 1'b1;
                code_d[2*i +: 2] = 2'b11;
              end else begin
                pass_d[i] = 1'b1;
              end
            end
          end
          default: state_d[i] = IDLE;
        endcase
      end
    end
    err_d = err_q | (|fail_d);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NCH; i++) begin
        state_q[i] <= IDLE;
        cnt_q[i]   <= '0;
      end
      pass_q <= '0;
      fail_q <= '0;
      code_q <= '0;
      len_q  <= '0;
      err_q  <= 1'b0;
    end else begin
      for (int i = 0; i < NCH; i++) begin
        state_q[i] <= state_d[i];
        cnt_q[i]   <= cnt_d[i];
      end
      pass_q <= pass_d;
      fail_q <= fail_d;
      code_q <= code_d;
      len_q  <= len_d;
      err_q  <= err_d;
    end
  end

  always_comb begin
    active_w = '0;
    for (int i = 0; i < NCH; i++) begin
      active_w[i] = (state_q[i] == RUN);
    end
  end

  assign bus.active     = active_w;
  assign bus.pass       = pass_q;
  assign bus.fail       = fail_q;
  assign bus.fail_code  = code_q;
  assign bus.run_len    = len_q;
  assign bus.err_sticky = err_q;

endmodule

// File: tb/tb_rep_window_checker.sv
// Bench for rep_window_checker: a bounded (2..4) and an unbounded (CW=3) build
// driven in lockstep, checked against a run-length reference model.
module tb_rep_window_checker;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  rep_window_if #(.NCH(4), .CW(8)) b0 ();
  rep_window_if #(.NCH(4), .CW(3)) b1 ();

  rep_window_checker #(.NCH(4), .MIN_REP(2), .MAX_REP(4), .CW(8)) dut0 (
    .clk(clk), .rst(rst), .bus(b0.slave)
  );
  rep_window_checker #(.NCH(4), .MIN_REP(2), .MAX_REP(0), .CW(3)) dut1 (
    .clk(clk), .rst(rst), .bus(b1.slave)
  );

  // reference model: k=0 bounded build, k=1 unbounded build
  bit m_run  [2][4];
  int m_n    [2][4];
  bit m_pass [2][4];
  bit m_fail [2][4];
  int m_code [2][4];
  int m_len  [2][4];
  bit m_err  [2];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_err[k] = 0;
      for (int ch = 0; ch < 4; ch++) begin
        m_run[k][ch] = 0; m_n[k][ch] = 0; m_pass[k][ch] = 0;
        m_fail[k][ch] = 0; m_code[k][ch] = 0; m_len[k][ch] = 0;
      end
    end
  endtask

  task automatic model_step(input bit e, input logic [3:0] t, input logic [3:0] c,
                            input logic [3:0] d);
    int maxr, sat;
    for (int k = 0; k < 2; k++) begin
      maxr = (k == 0) ? 4 : 0;
      sat  = (k == 0) ? 255 : 7;
      for (int ch = 0; ch < 4; ch++) begin
        m_pass[k][ch] = 0;
        m_fail[k][ch] = 0;
        if (!e) begin
          m_run[k][ch] = 0;
        end else if (!m_run[k][ch]) begin
          if (t[ch]) begin m_run[k][ch] = 1; m_n[k][ch] = 0; end
        end else if (c[ch]) begin
          if (maxr != 0 && m_n[k][ch] >= maxr) begin
            m_fail[k][ch] = 1; m_code[k][ch] = 2;
            m_len[k][ch] = m_n[k][ch]; m_run[k][ch] = 0;
          end else begin
            m_n[k][ch]++;
          end
        end else begin
          m_len[k][ch] = (m_n[k][ch] > sat) ? sat : m_n[k][ch];
          m_run[k][ch] = 0;
          if (m_n[k][ch] < 2)  begin m_fail[k][ch] = 1; m_code[k][ch] = 1; end
          else if (!d[ch])     begin m_fail[k][ch] = 1; m_code[k][ch] = 3; end
          else                 m_pass[k][ch] = 1;
        end
        if (m_fail[k][ch]) m_err[k] = 1;
      end
    end
  endtask

  task automatic check_all();
    logic [63:0] act, ps, fl, code, len;
    for (int k = 0; k < 2; k++) begin
      act = 0; ps = 0; fl = 0; code = 0; len = 0;
      for (int ch = 0; ch < 4; ch++) begin
        act[ch]  = m_run[k][ch];
        ps[ch]   = m_pass[k][ch];
        fl[ch]   = m_fail[k][ch];
        code    |= 64'(m_code[k][ch]) << (2 * ch);
        len     |= 64'(m_len[k][ch]) << (((k == 0) ? 8 : 3) * ch);
      end
      if (k == 0) begin
        chk("active0", 64'(b0.active), act);
        chk("pass0", 64'(b0.pass), ps);
        chk("fail0", 64'(b0.fail), fl);
        chk("code0", 64'(b0.fail_code), code);
        chk("len0", 64'(b0.run_len), len);
        chk("err0", 64'(b0.err_sticky), 64'(m_err[0]));
        chk("excl0", 64'(b0.pass & b0.fail), 64'd0);
      end else begin
        chk("active1", 64'(b1.active), act);
        chk("pass1", 64'(b1.pass), ps);
        chk("fail1", 64'(b1.fail), fl);
        chk("code1", 64'(b1.fail_code), code);
        chk("len1", 64'(b1.run_len), len);
        chk("err1", 64'(b1.err_sticky), 64'(m_err[1]));
      end
    end
  endtask

  task automatic step(input bit e, input logic [3:0] t, input logic [3:0] c,
                      input logic [3:0] d);
    @(negedge clk);
    b0.en = e; b0.trig = t; b0.cond = c; b0.done = d;
    b1.en = e; b1.trig = t; b1.cond = c; b1.done = d;
    @(posedge clk);
    model_step(e, t, c, d);
    #1;
    check_all();
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_act"}, 64'(b0.active | b1.active), 64'd0);
    chk({tag, "_pf"}, 64'(b0.pass | b0.fail | b1.pass | b1.fail), 64'd0);
    chk({tag, "_code"}, 64'(b0.fail_code | b1.fail_code), 64'd0);
    chk({tag, "_len"}, 64'(b0.run_len) | 64'(b1.run_len), 64'd0);
    chk({tag, "_err"}, 64'(b0.err_sticky | b1.err_sticky), 64'd0);
  endtask

  initial begin
    b0.en = 0; b0.trig = 0; b0.cond = 0; b0.done = 0;
    b1.en = 0; b1.trig = 0; b1.cond = 0; b1.done = 0;
    model_reset();
    #12;
    check_zero("reset");
    @(negedge clk);
    rst = 0;

    // ch0 pass len 3 alongside ch3 missing-done
    step(1, 4'b1001, 4'b0000, 4'b0000);
    step(1, 4'b0000, 4'b1001, 4'b0000);
    step(1, 4'b0000, 4'b1001, 4'b0000);
    step(1, 4'b0000, 4'b0001, 4'b0000);
    chk("ch3_fail", 64'(b0.fail[3]), 64'd1);
    chk("ch3_code", 64'(b0.fail_code[7:6]), 64'd3);
    step(1, 4'b0000, 4'b0000, 4'b0001);
    chk("ch0_pass", 64'(b0.pass[0]), 64'd1);
    chk("ch0_len", 64'(b0.run_len[7:0]), 64'd3);
    step(1, 4'b0000, 4'b0000, 4'b0000);
    chk("ch0_pulse_once", 64'(b0.pass[0]), 64'd0);

    // ch1 too short
    step(1, 4'b0010, 4'b0000, 4'b0000);
    step(1, 4'b0000, 4'b0010, 4'b0000);
    step(1, 4'b0000, 4'b0000, 4'b0010);
    chk("ch1_code", 64'(b0.fail_code[3:2]), 64'd1);
    chk("ch1_len", 64'(b0.run_len[15:8]), 64'd1);

    // ch2 overrun on 5th cond cycle; trig in terminating cycle ignored
    step(1, 4'b0100, 4'b0000, 4'b0000);
    for (int i = 0; i < 4; i++) step(1, 4'b0000, 4'b0100, 4'b0000);
    step(1, 4'b0100, 4'b0100, 4'b0000);
    chk("ch2_code", 64'(b0.fail_code[5:4]), 64'd2);
    chk("ch2_len", 64'(b0.run_len[23:16]), 64'd4);
    chk("ch2_idle", 64'(b0.active[2]), 64'd0);
    step(1, 4'b0000, 4'b0100, 4'b0000);
    step(1, 4'b0000, 4'b0000, 4'b1111);

    // unbounded build saturates at 7
    step(1, 4'b0001, 4'b0000, 4'b0000);
    for (int i = 0; i < 10; i++) step(1, 4'b0000, 4'b0001, 4'b0000);
    step(1, 4'b0000, 4'b0000, 4'b0001);
    chk("unb_pass", 64'(b1.pass[0]), 64'd1);
    chk("unb_len", 64'(b1.run_len[2:0]), 64'd7);

    // en drop mid-run
    step(1, 4'b1111, 4'b0000, 4'b0000);
    step(1, 4'b0000, 4'b1111, 4'b0000);
    step(0, 4'b0000, 4'b1111, 4'b1111);
    chk("en_act", 64'(b0.active), 64'd0);
    chk("en_pf", 64'(b0.pass | b0.fail), 64'd0);

    // async reset mid-run
    step(1, 4'b1111, 4'b0000, 4'b0000);
    step(1, 4'b0000, 4'b1111, 4'b0000);
    @(negedge clk);
    rst = 1;
    #1;
    model_reset();
    check_zero("rst_mid");
    @(negedge clk);
    rst = 0;
    step(1, 4'b0001, 4'b0000, 4'b0000);
    chk("restart", 64'(b0.active[0]), 64'd1);

    // randomized traffic
    for (int n = 0; n < 1500; n++) begin
      logic [3:0] t, c, d;
      bit e;
      e = ($urandom_range(15) != 0);
      for (int ch = 0; ch < 4; ch++) begin
        t[ch] = ($urandom_range(2) == 0);
        c[ch] = ($urandom_range(3) != 0);
        d[ch] = $urandom_range(1);
      end
      step(e, t, c, d);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/rep_window_checker.md
REP_WINDOW_CHECKER -- requirements
Module: rep_window_checker

Interface
REQ-001 Parameter NCH, default 4: number of independent monitor channels, legal range 1..32.
REQ-002 Parameter MIN_REP, default 2: minimum consecutive cond cycles, legal range 0..MAX_REP, or any value when MAX_REP=0.
REQ-003 Parameter MAX_REP, default 4: maximum consecutive cond cycles; 0 means unbounded (the [*MIN:$] form).
REQ-004 Parameter CW, default 8: run-counter width; SHALL satisfy 2^CW-1 >= max(MIN_REP, MAX_REP).
REQ-005 clk  input  1  sole clock; all state updates on the rising edge.
REQ-006 rst  input  1  asynchronous, active-high reset.
REQ-007 en  input  1  global enable; low aborts all channels.
REQ-008 trig  input  NCH  per-channel sequence start (the "req" term).
REQ-009 cond  input  NCH  per-channel repeated term (the "busy" term).
REQ-010 done  input  NCH  per-channel terminating term (the "ready" term).
REQ-011 active  output  NCH  channel is in RUN.
REQ-012 pass  output  NCH  one-cycle pulse on a successful match.
REQ-013 fail  output  NCH  one-cycle pulse on a violation.
REQ-014 fail_code  output  2*NCH  per-channel cause, valid with fail: 01 short, 10 overrun, 11 missing done.
REQ-015 run_len  output  CW*NCH  per-channel final run count, latched with pass or fail.
REQ-016 err_sticky  output  1  set by any fail; cleared only by reset.

Function
REQ-017 Each channel SHALL be an independent FSM with states IDLE and RUN, with a run counter cnt.
REQ-018 IDLE: when en=1 and trig=1, the channel SHALL move to RUN with cnt=0; trig SHALL be ignored in all other cases.
REQ-019 RUN with cond=1 and either MAX_REP=0 or cnt<MAX_REP: cnt SHALL increment, saturating at 2^CW-1, and the channel SHALL remain in RUN.
REQ-020 RUN with cond=1 and MAX_REP!=0 and cnt==MAX_REP: the channel SHALL fail with code 10 and move to IDLE.
REQ-021 RUN with cond=0 and cnt<MIN_REP: the channel SHALL fail with code 01 and move to IDLE; code 01 SHALL take priority over code 11.
REQ-022 RUN with cond=0, cnt>=MIN_REP and done=0: the channel SHALL fail with code 11 and move to IDLE.
REQ-023 RUN with cond=0, cnt>=MIN_REP and done=1: the channel SHALL pass and move to IDLE.
REQ-024 pass, fail, fail_code and run_len SHALL be registered; they SHALL be valid in the cycle after the clock edge that samples the deciding inputs (latency 1).
REQ-025 pass and fail SHALL never be high together, and each SHALL be high for exactly one cycle per event.
REQ-026 fail_code and run_len SHALL hold their value until the next event on the same channel.
REQ-027 A trig arriving in the terminating cycle SHALL be ignored; the earliest restart is the following cycle.
REQ-028 en=0 SHALL force every channel to IDLE on the next edge with no pass or fail pulse; run_len and fail_code SHALL be unchanged.
REQ-029 The first cond sample SHALL be taken in the cycle after trig (trig ##1 cond[*...]).
REQ-030 With MIN_REP=0, cond=0 in the first RUN cycle together with done=1 SHALL pass with run_len=0.

Reset
REQ-031 While rst=1: all channels SHALL be in IDLE, and active, pass, fail, fail_code, run_len and err_sticky SHALL all be 0.
REQ-032 rst asserted mid-RUN SHALL abort the run immediately (asynchronously) with no pulse; the first edge after release SHALL evaluate trig normally.

Verification (NCH=4, MIN_REP=2, MAX_REP=4, CW=8)
REQ-033 ch0: trig, then cond for 3 cycles, then cond=0 with done=1 -> pass[0] one cycle later, run_len[0]=3, fail=0.
REQ-034 ch1: trig, then cond for 1 cycle, then cond=0 with done=1 -> fail[1] with code 01, run_len=1, err_sticky=1.
REQ-035 ch2: trig, then cond held for 6 cycles -> fail[2] with code 10 after the 5th cond cycle, run_len=4, and the channel idle.
REQ-036 ch3: trig, then cond for 2 cycles, then cond=0 with done=0 -> fail[3] with code 11; a concurrent ch0 pass is unaffected.
REQ-037 Unbounded build (MAX_REP=0, CW=3): cond held for 10 cycles, then done -> pass, run_len=7 (saturated).
REQ-038 en dropped mid-RUN and, in a separate run, rst asserted mid-RUN -> no pulse and active=0; after rst, err_sticky=0.
